// File: rtl/decode.sv
// In-order decode stage: legality check, immediate generation, register file and busy scoreboard.
// Defining WB_BYPASS_EN forwards same-edge writeback data to the sources and the hazard check.

`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef EX_WIDTH
`define EX_WIDTH 3
`endif
`ifndef EX_ILLEGAL_INSTR
`define EX_ILLEGAL_INSTR 2
`endif

module decode #(
    parameter int REG_COUNT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [`INSTR_SIZE:0]  instr,
    input  logic [`ADDR_SIZE:0]   PC,
    input  logic [`EX_WIDTH:0]    exception,
    input  logic                  exception_valid,
    input  logic                  pipeline_valid,
    output logic                  stall,
    input  logic                  flush,
    input  logic                  ex_stall,
    input  logic                  wb_enable,
    input  logic [4:0]            wb_rd,
    input  logic [`INSTR_SIZE:0]  wb_data,
    output logic [`ADDR_SIZE:0]   d_PC,
    output logic [6:0]            d_opcode,
    output logic [2:0]            d_funct3,
    output logic [6:0]            d_funct7,
    output logic [4:0]            d_rd,
    output logic [`INSTR_SIZE:0]  d_rs1_data,
    output logic [`INSTR_SIZE:0]  d_rs2_data,
    output logic [31:0]           d_imm,
    output logic [`EX_WIDTH:0]    d_exception,
    output logic                  d_exception_valid,
    output logic                  d_valid
);

    localparam int XLEN  = `INSTR_SIZE + 1;
    localparam int AW    = `ADDR_SIZE + 1;
    localparam int EXW   = `EX_WIDTH + 1;
    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [5:0]     REG_LIMIT  = 6'(REG_COUNT);
    localparam logic [EXW-1:0] EX_ILLEGAL = EXW'(`EX_ILLEGAL_INSTR);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011,
        OPC_FENCE  = 7'b0001111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [AW-1:0]   pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [31:0]     imm;
        logic [EXW-1:0]  exception;
        logic            exception_valid;
        logic            valid;
    } dec_out_t;

    dec_out_t             out_q, out_d;
    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic [XLEN-1:0]      regs_q [REG_COUNT];
    logic [XLEN-1:0]      regs_d [REG_COUNT];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic        legal, rd_used, rs1_used, rs2_used;
    logic [31:0] imm;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        legal    = 1'b0;
        rd_used  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        imm      = '0;
        if (instr[1:0] == 2'b11) begin
            case (opcode)
                OPC_LUI, OPC_AUIPC: begin legal = 1'b1; rd_used = 1'b1; imm = imm_u; end
                OPC_JAL:            begin legal = 1'b1; rd_used = 1'b1; imm = imm_j; end
                OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                    legal = 1'b1; rd_used = 1'b1; rs1_used = 1'b1; imm = imm_i;
                end
                OPC_BRANCH: begin legal = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; imm = imm_b; end
                OPC_STORE:  begin legal = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; imm = imm_s; end
                OPC_OP: begin legal = 1'b1; rd_used = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
                OPC_FENCE, OPC_SYSTEM: legal = 1'b1;
                default: ;
            endcase
        end
        if (rd == 5'd0) rd_used = 1'b0;
    end

    logic [IDX_W-1:0] rs1_idx, rs2_idx, rd_idx, wb_idx;
    logic             rs1_ok, rs2_ok, rd_ok, wb_ok, wb_write;
    logic             byp1, byp2, busy1, busy2;
    logic [XLEN-1:0]  rs1_data, rs2_data;

    assign rs1_idx  = rs1[IDX_W-1:0];
    assign rs2_idx  = rs2[IDX_W-1:0];
    assign rd_idx   = rd[IDX_W-1:0];
    assign wb_idx   = wb_rd[IDX_W-1:0];
    assign rs1_ok   = (rs1 != 5'd0) && ({1'b0, rs1} < REG_LIMIT);
    assign rs2_ok   = (rs2 != 5'd0) && ({1'b0, rs2} < REG_LIMIT);
    assign rd_ok    = (rd != 5'd0) && ({1'b0, rd} < REG_LIMIT);
    assign wb_ok    = (wb_rd != 5'd0) && ({1'b0, wb_rd} < REG_LIMIT);
    assign wb_write = wb_enable & wb_ok;

`ifdef WB_BYPASS_EN
    assign byp1 = wb_write && (wb_rd == rs1);
    assign byp2 = wb_write && (wb_rd == rs2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // A source being written back this edge is no longer waiting once bypass supplies the data.
    assign busy1    = rs1_ok & busy_q[rs1_idx] & ~byp1;
    assign busy2    = rs2_ok & busy_q[rs2_idx] & ~byp2;
    assign rs1_data = !rs1_ok ? '0 : (byp1 ? wb_data : regs_q[rs1_idx]);
    assign rs2_data = !rs2_ok ? '0 : (byp2 ? wb_data : regs_q[rs2_idx]);

    logic hazard, issue, set_busy;

    assign hazard   = pipeline_valid & ~exception_valid & legal &
                      ((rs1_used & busy1) | (rs2_used & busy2));
    assign stall    = reset & pipeline_valid & (hazard | ex_stall);
    assign issue    = pipeline_valid & ~hazard & ~ex_stall & ~flush;
    assign set_busy = issue & ~exception_valid & legal & rd_used & rd_ok;

    always_comb begin
        out_d = out_q;
        if (flush) begin
            out_d.valid           = 1'b0;
            out_d.exception_valid = 1'b0;
        end else if (!ex_stall) begin
            if (issue) begin
                out_d.pc              = PC;
                out_d.opcode          = opcode;
                out_d.funct3          = instr[14:12];
                out_d.funct7          = instr[31:25];
                out_d.rd              = rd;
                out_d.rs1_data        = rs1_data;
                out_d.rs2_data        = rs2_data;
                out_d.imm             = imm;
                out_d.valid           = 1'b1;
                out_d.exception_valid = exception_valid | ~legal;
                out_d.exception       = exception_valid ? exception :
                                        (legal ? '0 : EX_ILLEGAL);
            end else begin
                out_d.valid = 1'b0;
            end
        end
    end

    // Clear before set so an issue to the register being written back keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_write) busy_d[wb_idx] = 1'b0;
        if (set_busy) busy_d[rd_idx] = 1'b1;
        if (flush)    busy_d = '0;
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_write) regs_d[wb_idx] = wb_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q  <= '0;
            busy_q <= '0;
            // NOTE: the register file is reset because software may read a register before writing it.
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            out_q  <= out_d;
            busy_q <= busy_d;
            regs_q <= regs_d;
        end
    end

    assign d_PC              = out_q.pc;
    assign d_opcode          = out_q.opcode;
    assign d_funct3          = out_q.funct3;
    assign d_funct7          = out_q.funct7;
    assign d_rd              = out_q.rd;
    assign d_rs1_data        = out_q.rs1_data;
    assign d_rs2_data        = out_q.rs2_data;
    assign d_imm             = out_q.imm;
    assign d_exception       = out_q.exception;
    assign d_exception_valid = out_q.exception_valid;
    assign d_valid           = out_q.valid;

endmodule

// File: tb/tb_decode.sv
// Directed scoreboard bench for decode: reset, RAW hazard, illegal, exception, flush, ex_stall, immediates.

`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef EX_WIDTH
`define EX_WIDTH 3
`endif
`ifndef EX_ILLEGAL_INSTR
`define EX_ILLEGAL_INSTR 2
`endif

module tb_decode;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [`INSTR_SIZE:0] instr;
    logic [`ADDR_SIZE:0]  PC;
    logic [`EX_WIDTH:0]   exception;
    logic                 exception_valid;
    logic                 pipeline_valid;
    logic                 stall;
    logic                 flush;
    logic                 ex_stall;
    logic                 wb_enable;
    logic [4:0]           wb_rd;
    logic [`INSTR_SIZE:0] wb_data;
    logic [`ADDR_SIZE:0]  d_PC;
    logic [6:0]           d_opcode;
    logic [2:0]           d_funct3;
    logic [6:0]           d_funct7;
    logic [4:0]           d_rd;
    logic [`INSTR_SIZE:0] d_rs1_data;
    logic [`INSTR_SIZE:0] d_rs2_data;
    logic [31:0]          d_imm;
    logic [`EX_WIDTH:0]   d_exception;
    logic                 d_exception_valid;
    logic                 d_valid;

    always #5 clk = ~clk;

    decode #(.REG_COUNT(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .PC(PC),
        .exception(exception), .exception_valid(exception_valid),
        .pipeline_valid(pipeline_valid), .stall(stall), .flush(flush),
        .ex_stall(ex_stall), .wb_enable(wb_enable), .wb_rd(wb_rd), .wb_data(wb_data),
        .d_PC(d_PC), .d_opcode(d_opcode), .d_funct3(d_funct3), .d_funct7(d_funct7),
        .d_rd(d_rd), .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data), .d_imm(d_imm),
        .d_exception(d_exception), .d_exception_valid(d_exception_valid), .d_valid(d_valid)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
        bit          c1;
        bit          c2;
        bit          full;
        bit          exv;
        logic [3:0]  exc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
        instr           = ins;
        PC              = pc;
        pipeline_valid  = 1'b1;
        exception_valid = 1'b0;
        exception       = '0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] imm,
                        input logic [31:0] r1, input bit c1, input logic [31:0] r2, input bit c2,
                        input bit full, input bit exv, input logic [3:0] exc);
        exp_t e;
        e.pc = pc; e.ins = ins; e.imm = imm; e.r1 = r1; e.r2 = r2;
        e.c1 = c1; e.c2 = c2; e.full = full; e.exv = exv; e.exc = exc;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, ".avail"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, ".valid"}, 32'(d_valid), 32'd1);
        check({tag, ".pc"}, 32'(d_PC), e.pc);
        if (e.full) begin
            check({tag, ".opcode"}, 32'(d_opcode), 32'(e.ins[6:0]));
            check({tag, ".funct3"}, 32'(d_funct3), 32'(e.ins[14:12]));
            check({tag, ".funct7"}, 32'(d_funct7), 32'(e.ins[31:25]));
            check({tag, ".rd"}, 32'(d_rd), 32'(e.ins[11:7]));
            check({tag, ".imm"}, d_imm, e.imm);
        end
        check({tag, ".exc_valid"}, 32'(d_exception_valid), 32'(e.exv));
        if (e.exv) check({tag, ".exc"}, 32'(d_exception), 32'(e.exc));
        if (e.c1) check({tag, ".rs1"}, 32'(d_rs1_data), e.r1);
        if (e.c2) check({tag, ".rs2"}, 32'(d_rs2_data), e.r2);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; ex_stall = 1'b0;
        wb_enable = 1'b0; wb_rd = '0; wb_data = '0;
        drive(32'h0000_0013, 32'h100);

        // Reset held with a valid NOP presented.
        #2;
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.valid", 32'(d_valid), 32'd0);
        check("rst.exc_valid", 32'(d_exception_valid), 32'd0);
        check("rst.imm", d_imm, 32'd0);
        check("rst.pc", 32'(d_PC), 32'd0);
        tick(); tick();
        check("rst.valid_edges", 32'(d_valid), 32'd0);
        check("rst.stall_edges", 32'(stall), 32'd0);

        reset = 1'b1;
        push(32'h100, 32'h0000_0013, 32'd0, 32'd0, 1, 32'd0, 1, 1, 0, 4'd0);
        tick();
        pop_check("nop");

        // RAW: ADDI x5,x0,7 then ADD x6,x5,x5.
        drive(32'h0070_0293, 32'h104);
        push(32'h104, 32'h0070_0293, 32'd7, 32'd0, 1, 32'd0, 0, 1, 0, 4'd0);
        tick();
        pop_check("addi_x5");
        drive(32'h0052_8333, 32'h108);
        push(32'h108, 32'h0052_8333, 32'd0, 32'd7, 1, 32'd7, 1, 1, 0, 4'd0);
        #1 check("raw.stall", 32'(stall), 32'd1);
        tick();
        check("raw.bubble1", 32'(d_valid), 32'd0);
        check("raw.stall1", 32'(stall), 32'd1);
        tick();
        check("raw.bubble2", 32'(d_valid), 32'd0);
        wb_enable = 1'b1; wb_rd = 5'd5; wb_data = 32'd7;
`ifdef WB_BYPASS_EN
        #1 check("raw.stall_wb", 32'(stall), 32'd0);
        tick();
        wb_enable = 1'b0;
        pop_check("raw_add");
`else
        #1 check("raw.stall_wb", 32'(stall), 32'd1);
        tick();
        wb_enable = 1'b0;
        check("raw.bubble_wb", 32'(d_valid), 32'd0);
        #1 check("raw.stall_after_wb", 32'(stall), 32'd0);
        tick();
        pop_check("raw_add");
`endif

        // Illegal instruction, with x6 written back on the same edge.
        drive(32'hFFFF_FFFF, 32'h10C);
        wb_enable = 1'b1; wb_rd = 5'd6; wb_data = 32'd14;
        push(32'h10C, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 32'd0, 0, 0, 1, 4'(`EX_ILLEGAL_INSTR));
        #1 check("illegal.stall", 32'(stall), 32'd0);
        tick();
        wb_enable = 1'b0;
        pop_check("illegal");
        drive(32'h000F_84B3, 32'h110);
        push(32'h110, 32'h000F_84B3, 32'd0, 32'd0, 1, 32'd0, 1, 1, 0, 4'd0);
        #1 check("illegal.no_busy_x31", 32'(stall), 32'd0);
        tick();
        pop_check("add_x9");

        // Forwarded fetch exception: ADD x10,x9,x6 with x9 busy raises no hazard.
        drive(32'h0064_8533, 32'h114);
        exception_valid = 1'b1; exception = 4'd5;
        push(32'h114, 32'h0064_8533, 32'd0, 32'd0, 1, 32'd14, 1, 1, 1, 4'd5);
        #1 check("exc.stall", 32'(stall), 32'd0);
        tick();
        pop_check("exc_fwd");
        drive(32'h0005_07B3, 32'h118);
        push(32'h118, 32'h0005_07B3, 32'd0, 32'd0, 1, 32'd0, 1, 1, 0, 4'd0);
        #1 check("exc.no_busy_x10", 32'(stall), 32'd0);
        tick();
        pop_check("add_x15");

        // Flush after LW x7 issues; x3 written back on the flush edge.
        drive(32'h0000_2383, 32'h11C);
        push(32'h11C, 32'h0000_2383, 32'd0, 32'd0, 1, 32'd0, 0, 1, 0, 4'd0);
        tick();
        pop_check("lw_x7");
        drive(32'h0003_8433, 32'h120);
        #1 check("flush.pre_stall", 32'(stall), 32'd1);
        flush = 1'b1; wb_enable = 1'b1; wb_rd = 5'd3; wb_data = 32'hABCD;
        tick();
        flush = 1'b0; wb_enable = 1'b0;
        check("flush.valid", 32'(d_valid), 32'd0);
        check("flush.exc_valid", 32'(d_exception_valid), 32'd0);
        push(32'h120, 32'h0003_8433, 32'd0, 32'd0, 1, 32'd0, 1, 1, 0, 4'd0);
        #1 check("flush.busy_cleared", 32'(stall), 32'd0);
        tick();
        pop_check("add_x8");

        // ex_stall for three edges with ADDI x11,x3,1 held.
        drive(32'h0011_8593, 32'h124);
        ex_stall = 1'b1;
        push(32'h124, 32'h0011_8593, 32'd1, 32'hABCD, 1, 32'd0, 0, 1, 0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            #1 check("exs.stall", 32'(stall), 32'd1);
            tick();
            check("exs.valid", 32'(d_valid), 32'd1);
            check("exs.pc", 32'(d_PC), 32'h120);
            check("exs.rd", 32'(d_rd), 32'd8);
        end
        ex_stall = 1'b0;
        #1 check("exs.release_stall", 32'(stall), 32'd0);
        tick();
        pop_check("addi_x11");

        // Immediate formats.
        drive(32'hFE00_0EE3, 32'h128);
        push(32'h128, 32'hFE00_0EE3, 32'hFFFF_FFFC, 32'd0, 1, 32'd0, 1, 1, 0, 4'd0);
        tick();
        pop_check("beq");
        drive(32'hFE50_2C23, 32'h12C);
        push(32'h12C, 32'hFE50_2C23, 32'hFFFF_FFF8, 32'd0, 1, 32'd7, 1, 1, 0, 4'd0);
        tick();
        pop_check("sw");
        drive(32'h1234_50B7, 32'h130);
        push(32'h130, 32'h1234_50B7, 32'h1234_5000, 32'd0, 0, 32'd0, 0, 1, 0, 4'd0);
        tick();
        pop_check("lui");
        drive(32'h0080_016F, 32'h134);
        push(32'h134, 32'h0080_016F, 32'd8, 32'd0, 0, 32'd0, 0, 1, 0, 4'd0);
        tick();
        pop_check("jal");

        pipeline_valid = 1'b0;
        tick();
        check("bubble.valid", 32'(d_valid), 32'd0);
        check("bubble.stall", 32'(stall), 32'd0);

        // Reset while ADD x12,x1,x1 waits on x1.
        drive(32'h0010_8633, 32'h138);
        #1 check("midrst.stall", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst.stall_rst", 32'(stall), 32'd0);
        check("midrst.valid", 32'(d_valid), 32'd0);
        check("midrst.imm", d_imm, 32'd0);
        check("midrst.pc", 32'(d_PC), 32'd0);
        tick();
        reset = 1'b1; pipeline_valid = 1'b0;
        tick();
        check("midrst.no_issue", 32'(d_valid), 32'd0);
        drive(32'h0001_86B3, 32'h13C);
        push(32'h13C, 32'h0001_86B3, 32'd0, 32'd0, 1, 32'd0, 1, 1, 0, 4'd0);
        #1 check("midrst.stall_after", 32'(stall), 32'd0);
        tick();
        pop_check("add_x13");

        check("sb.drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
